// File: rtl/rf_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_sequencer
// Purpose  : Merges pipeline (A) and buffered long-latency (B) results onto the
//            single register-file write port; tracks pending destinations.
// Revision : 1.0 - initial release
// ============================================================================
module rf_write_sequencer #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    input  logic        iss_valid,
    input  logic [4:0]  iss_addr,
    input  logic [4:0]  q1_addr,
    input  logic [4:0]  q2_addr,
    output logic        q1_pending,
    output logic        q2_pending,
    output logic        stall_req,
    output logic        waw_err,
    output logic [4:0]  write_addr,
    output logic [31:0] write_data,
    output logic        write_enabled
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] C_LIMIT = CW'(STARVE_LIMIT);

    logic [4:0]    r_fifo_addr [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [31:0]   r_pending;
    logic [CW-1:0] r_starve_cnt;
    logic          r_stall;
    logic          r_waw;
    logic          r_we;
    logic [4:0]    r_waddr;
    logic [31:0]   r_wdata;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [4:0]    w_head_addr;
    logic [31:0]   w_head_data;
    logic          w_sel_valid;
    logic [4:0]    w_sel_addr;
    logic [31:0]   w_sel_data;
    logic [31:0]   w_clr_mask;
    logic [31:0]   w_set_mask;
    logic          w_starve;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = b_valid && !w_full;
    assign w_pop   = !a_valid && !w_empty;
    assign w_head_addr = r_fifo_addr[r_rd_ptr[AW-1:0]];
    assign w_head_data = r_fifo_data[r_rd_ptr[AW-1:0]];
    assign w_starve    = a_valid && !w_empty;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_addr  = 5'd0;
        w_sel_data  = 32'd0;
        if (a_valid) begin
            w_sel_valid = 1'b1;
            w_sel_addr  = a_addr;
            w_sel_data  = a_data;
        end else if (!w_empty) begin
            w_sel_valid = 1'b1;
            w_sel_addr  = w_head_addr;
            w_sel_data  = w_head_data;
        end
    end

    assign w_clr_mask = w_pop     ? (32'd1 << w_head_addr) : 32'd0;
    assign w_set_mask = iss_valid ? (32'd1 << iss_addr)    : 32'd0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr[AW-1:0]] <= b_addr;
            r_fifo_data[r_wr_ptr[AW-1:0]] <= b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Address-0 entries still load the stage but never assert the enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_waddr <= 5'd0;
            r_wdata <= 32'd0;
        end else begin
            r_we <= w_sel_valid && (w_sel_addr != 5'd0);
            if (w_sel_valid) begin
                r_waddr <= w_sel_addr;
                r_wdata <= w_sel_data;
            end
        end
    end

    // Set is applied after clear so a same-cycle issue keeps the bit pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 32'd0;
        end else begin
            r_pending <= ((r_pending & ~w_clr_mask) | w_set_mask) & ~32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_waw <= 1'b0;
        end else if (a_valid && (a_addr != 5'd0) && r_pending[a_addr]) begin
            r_waw <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_stall      <= 1'b0;
        end else begin
            r_stall <= (r_starve_cnt == C_LIMIT);
            if (!w_starve) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != C_LIMIT) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    assign b_ready       = !w_full;
    assign q1_pending    = r_pending[q1_addr];
    assign q2_pending    = r_pending[q2_addr];
    assign stall_req     = r_stall;
    assign waw_err       = r_waw;
    assign write_enabled = r_we;
    assign write_addr    = r_waddr;
    assign write_data    = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_write_sequencer
// Purpose  : Randomised and directed stimulus with a queue-based reference model
//            and a decoupled write-port scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_write_sequencer;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0;
    logic [4:0]  a_addr = 5'd0;
    logic [31:0] a_data = 32'd0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [4:0]  b_addr = 5'd0;
    logic [31:0] b_data = 32'd0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_addr = 5'd0;
    logic [4:0]  q1_addr = 5'd0;
    logic [4:0]  q2_addr = 5'd0;
    logic        q1_pending;
    logic        q2_pending;
    logic        stall_req;
    logic        waw_err;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        write_enabled;

    always #5 clk = ~clk;

    rf_write_sequencer #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .q1_addr(q1_addr), .q2_addr(q2_addr),
        .q1_pending(q1_pending), .q2_pending(q2_pending),
        .stall_req(stall_req), .waw_err(waw_err),
        .write_addr(write_addr), .write_data(write_data),
        .write_enabled(write_enabled)
    );

    typedef struct { logic [4:0] addr; logic [31:0] data; int cyc; } wr_t;
    typedef struct { logic [4:0] addr; logic [31:0] data; } ent_t;

    wr_t         exp_q[$];
    ent_t        m_fifo[$];
    logic [31:0] m_pend = 32'd0;
    int          m_cnt = 0;
    bit          m_stall = 1'b0;
    bit          m_waw = 1'b0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive, check combinational/status outputs, advance the model.
    task automatic step(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                        input logic iv, input logic [4:0] ia, input logic [4:0] q1, input logic [4:0] q2);
        int          sz;
        bit          starve;
        logic [31:0] clr;
        ent_t        e;
        @(negedge clk);
        rst = r; a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        iss_valid = iv; iss_addr = ia; q1_addr = q1; q2_addr = q2;
        #1;
        check("b_ready",    32'(b_ready),    32'(m_fifo.size() < DEPTH));
        check("q1_pending", 32'(q1_pending), 32'(m_pend[q1]));
        check("q2_pending", 32'(q2_pending), 32'(m_pend[q2]));
        check("stall_req",  32'(stall_req),  32'(m_stall));
        check("waw_err",    32'(waw_err),    32'(m_waw));
        @(posedge clk);
        if (r) begin
            m_fifo.delete();
            m_pend = 32'd0; m_cnt = 0; m_stall = 1'b0; m_waw = 1'b0;
        end else begin
            sz = m_fifo.size();
            starve = av && (sz > 0);
            clr = 32'd0;
            if (av) begin
                if (aa != 5'd0) begin
                    exp_q.push_back('{aa, ad, cyc + 1});
                    if (m_pend[aa]) m_waw = 1'b1;
                end
            end else if (sz > 0) begin
                e = m_fifo.pop_front();
                if (e.addr != 5'd0) exp_q.push_back('{e.addr, e.data, cyc + 1});
                clr[e.addr] = 1'b1;
            end
            if (bv && sz < DEPTH) m_fifo.push_back('{ba, bd});
            m_pend = m_pend & ~clr;
            if (iv && ia != 5'd0) m_pend[ia] = 1'b1;
            m_stall = (m_cnt == LIMIT);
            m_cnt = starve ? ((m_cnt < LIMIT) ? m_cnt + 1 : LIMIT) : 0;
        end
        cyc++;
    endtask

    task automatic idle(input int n, input logic [4:0] q1);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, q1, 5'd0);
    endtask

    // Write-port monitor: every asserted write must match the oldest expected one.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                w = exp_q.pop_front();
                n_vec++; n_err++;
                $display("FAIL missing_write cycle %0d: got none expected addr %0d data %h", cyc, w.addr, w.data);
            end
            if (write_enabled) begin
                n_vec++;
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    n_err++;
                    $display("FAIL unexpected_write cycle %0d: got addr %0d data %h expected none", cyc, write_addr, write_data);
                end else begin
                    w = exp_q.pop_front();
                    if (write_addr !== w.addr || write_data !== w.data) begin
                        n_err++;
                        $display("FAIL write cycle %0d: got addr %0d data %h expected addr %0d data %h",
                                 cyc, write_addr, write_data, w.addr, w.data);
                    end
                end
            end
        end
    end

    initial begin
        logic        av, bv, iv, r;
        logic [4:0]  aa, ba, ia, q1, q2;
        int          pa;

        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        #2;
        check("reset_we",    32'(write_enabled), 32'd0);
        check("reset_waddr", 32'(write_addr),    32'd0);
        check("reset_wdata", write_data,         32'd0);

        // Single pipeline write
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(2, 5'd0);

        // Issue then long-latency completion to the same register
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h1234, 1'b0, 5'd0, 5'd9, 5'd9);
        idle(3, 5'd9);

        // Fill the FIFO under continuous port-A traffic, then drain
        for (int i = 0; i < 12; i++)
            step(1'b0, 1'b1, 5'(i + 1), 32'(i * 3 + 100), 1'b1, 5'(i + 10), 32'(i + 32'hB000),
                 1'b0, 5'd0, 5'd0, 5'd0);
        idle(7, 5'd0);

        // Address-0 traffic on both ports
        step(1'b0, 1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22, 1'b1, 5'd0, 5'd0, 5'd0);
        idle(3, 5'd0);

        // WAW on a pending register
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0);
        step(1'b0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0);
        idle(3, 5'd7);

        // Same-cycle set and clear of register 3
        step(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd3, 32'h33, 1'b1, 5'd3, 5'd3, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd0);
        idle(2, 5'd3);

        // Reset with entries queued: they must vanish
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 5'd2, 32'(i), 1'b1, 5'(i + 20), 32'(i), 1'b0, 5'd0, 5'd0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(4, 5'd20);

        // Randomised traffic with alternating busy/quiet segments
        for (int i = 0; i < 1200; i++) begin
            pa = ((i / 40) % 2 == 0) ? 92 : 35;
            r  = ($urandom_range(0, 299) == 0);
            av = ($urandom_range(0, 99) < pa);
            bv = ($urandom_range(0, 99) < 55);
            iv = ($urandom_range(0, 99) < 30);
            aa = 5'($urandom_range(0, 7));
            ba = 5'($urandom_range(0, 7));
            ia = 5'($urandom_range(0, 7));
            q1 = 5'($urandom_range(0, 7));
            q2 = 5'($urandom_range(0, 31));
            step(r, av, aa, $urandom, bv, ba, $urandom, iv, ia, q1, q2);
        end
        idle(DEPTH + 3, 5'd0);
        @(negedge clk);
        #1;
        check("drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
